mem_port_ctrl: RTL
==================

Name: mem_port_ctrl

Overview:
Parametrised MAR/MDR memory-port controller. It replaces bare MAR/MDR registers and the MIO_EN mux with a sequenced read/write engine. The engine drives an external SRAM with configurable wait states and signals completion to the control FSM via Ready. It sits between the datapath bus and the physical memory/IO pins.

Parameters:
DATA_W, 16, data width of bus, MDR and memory data
ADDR_W, 16, width of MAR and memory address
WAIT_CYCLES, 2, memory access wait states; legal range 1..15; elaboration error otherwise

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
BUS  input  DATA_W  datapath bus value
LD_MAR  input  1  load MAR from BUS[ADDR_W-1:0]
LD_MDR  input  1  load MDR, source chosen by MIO_EN
MIO_EN  input  1  0: MDR source is BUS; 1: MDR source is Mem_Rdata
Rd_Req  input  1  single-cycle read request pulse
Wr_Req  input  1  single-cycle write request pulse
Mem_Rdata  input  DATA_W  memory read data
Mem_Addr  output  ADDR_W  memory address; always equals MAR
Mem_Wdata  output  DATA_W  memory write data; always equals MDR
Mem_CE  output  1  chip enable, active-high
Mem_OE  output  1  output enable, active-high
Mem_WE  output  1  write enable, active-high
MAR  output  ADDR_W  memory address register
MDR  output  DATA_W  memory data register
Busy  output  1  high in SETUP and WAIT
Ready  output  1  high for exactly one cycle in DONE

Behaviour:
- Reset values:
  - MAR=0, MDR=0, state=IDLE.
  - Mem_CE, Mem_OE, Mem_WE, Busy and Ready are all 0.
  - Strobes drop immediately on Reset assertion, including mid-access.
- FSM states: IDLE, SETUP, WAIT, DONE. An op register records RD or WR.
- IDLE:
  - Wr_Req → SETUP with op=WR.
  - Else Rd_Req → SETUP with op=RD.
  - Both requests asserted together: write has priority and the read is dropped.
- SETUP (1 cycle):
  - Mem_CE=1. Mem_OE=1 if RD.
  - Wait counter loaded with WAIT_CYCLES-1.
  - Next state WAIT.
- WAIT (WAIT_CYCLES cycles):
  - Mem_CE=1. Mem_OE=1 if RD. Mem_WE=1 if WR.
  - Counter decrements each cycle; at 0, next state is DONE.
  - RD: MDR <= Mem_Rdata on the final WAIT edge.
- DONE (1 cycle): Ready=1, all strobes 0, next state IDLE.
- Latency:
  - Request cycle = cycle 0; Ready is high in cycle WAIT_CYCLES+2.
  - Next request is accepted in the cycle after DONE.
- Requests in SETUP/WAIT/DONE are ignored. They are not queued.
- LD_MAR and LD_MDR are honoured only in IDLE; they are ignored otherwise, so MAR and MDR stay stable during an access.
- LD_MAR together with a request in the same IDLE cycle: MAR updates at that edge, and the access uses the new MAR.
- LD_MDR together with Wr_Req: likewise, the write uses the new MDR.
- LD_MDR source: MIO_EN=0 loads BUS; MIO_EN=1 loads Mem_Rdata (legacy path).
- Width: BUS bits above ADDR_W are discarded on a MAR load. If ADDR_W > DATA_W, MAR is zero-extended.

Optional Feature:
Macro: MEM_PORT_PROTOCOL_CHK_EN
- Defined:
  - Adds output Err (1 bit) and an internal 4-bit saturating Drop_Cnt, exposed as output Drop_Cnt.
  - Err is sticky and set when Rd_Req or Wr_Req arrives outside IDLE, or when both are asserted in the same cycle.
  - Drop_Cnt increments once per such event and saturates at 15.
  - Both are cleared only by Reset.
- Undefined: the ports are absent and there is no logic; behaviour is otherwise identical.

Decomposition:
- Package mem_port_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} mem_state_t
  - typedef enum logic {OP_RD, OP_WR} mem_op_t
  - constant MAX_WAIT = 15
- Sub-module wait_counter: parametrised down-counter with load, dec and zero flag. It is reusable for future IO-port wait states.

Test Plan:
- Read, WAIT_CYCLES=2: LD_MAR with BUS=16'h0040, then Rd_Req, memory returns 16'hBEEF.
  → Mem_OE high for cycles 1–3; MDR=16'hBEEF; Ready high in cycle 4 only.
- Write: LD_MDR with BUS=16'h1234, MIO_EN=0, MAR=16'h0010, then Wr_Req.
  → Mem_WE high for exactly 2 cycles; Mem_Addr=16'h0010 and Mem_Wdata=16'h1234 throughout.
- Busy collision: Rd_Req during WAIT, plus LD_MAR with BUS=16'hFFFF.
  → Request ignored and MAR unchanged. With MEM_PORT_PROTOCOL_CHK_EN: Err=1, Drop_Cnt=1.
- Simultaneous Rd_Req and Wr_Req in IDLE.
  → Write performed, Mem_OE never asserted, Err=1 if the feature is enabled.
- Reset asserted mid-WAIT of a read.
  → Strobes low with no clock edge needed; MDR=0, MAR=0, state IDLE. A fresh Rd_Req after deassert completes normally.
- WAIT_CYCLES=1 back-to-back reads at 16'h0000 then 16'h0001.
  → Each Ready is 3 cycles after its request; the second request is accepted the cycle after the first DONE.

Source files
------------

// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared types and constants for the memory-port controller.
//   mem_state_t : access sequencer states
//   mem_op_t    : recorded operation for the access in flight
//   MAX_WAIT    : largest supported wait-state count
//   CNT_W       : width of the wait-state counter (holds 0..MAX_WAIT)
package mem_port_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} mem_state_t;
   typedef enum logic {OP_RD, OP_WR} mem_op_t;
   localparam int MAX_WAIT = 15;
   localparam int CNT_W    = 4;
endpackage

// File: rtl/mem_port_ctrl_wait_counter.sv
// wait_counter: loadable down-counter with zero flag, used to time memory
// wait states (and reusable for IO-port wait states).
//   clk, rst        : clock, async active-high reset
//   load, load_val  : load has priority over dec
//   dec             : decrement, holds at zero
//   cnt, zero       : current count and (cnt == 0)
module wait_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         zero
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     cnt <= '0;
      else if (load)               cnt <= load_val;
      else if (dec && cnt != '0)   cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: MAR/MDR memory-port controller. Sequences one SRAM read or
// write per request through IDLE -> SETUP -> WAIT (WAIT_CYCLES) -> DONE and
// pulses Ready in DONE.
//   Clk, Reset        : clock, async active-high reset
//   BUS               : datapath bus (MAR/MDR load source)
//   LD_MAR, LD_MDR    : register loads, honoured only in IDLE
//   MIO_EN            : MDR load source, 0 = BUS, 1 = Mem_Rdata
//   Rd_Req, Wr_Req    : single-cycle request pulses (write wins)
//   Mem_*             : SRAM address/data/strobes
//   MAR, MDR          : architectural registers
//   Busy, Ready       : Busy in SETUP/WAIT, Ready for one cycle in DONE
// Optional: define MEM_PORT_PROTOCOL_CHK_EN to add Err (sticky) and Drop_Cnt
// (saturating count of requests arriving outside IDLE or colliding).
module mem_port_ctrl
   import mem_port_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] BUS,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              MIO_EN,
   input  logic              Rd_Req,
   input  logic              Wr_Req,
   input  logic [DATA_W-1:0] Mem_Rdata,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_Wdata,
   output logic              Mem_CE,
   output logic              Mem_OE,
   output logic              Mem_WE,
   output logic [ADDR_W-1:0] MAR,
   output logic [DATA_W-1:0] MDR,
   output logic              Busy,
   output logic              Ready
`ifdef MEM_PORT_PROTOCOL_CHK_EN
   ,
   output logic              Err,
   output logic [3:0]        Drop_Cnt
`endif
);
   generate
      if (WAIT_CYCLES < 1 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
         $error("mem_port_ctrl: WAIT_CYCLES must be in 1..15");
      end
   endgenerate

   mem_state_t       state, state_nxt;
   mem_op_t          op;
   logic [CNT_W-1:0] wcnt;
   logic             wcnt_zero;
   logic             in_idle;

   assign in_idle = (state == IDLE);

   // SETUP preloads WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
   wait_counter #(.W(CNT_W)) u_wait_cnt (
      .clk      (Clk),
      .rst      (Reset),
      .load     (state == SETUP),
      .dec      (state == WAIT),
      .load_val (CNT_W'(WAIT_CYCLES - 1)),
      .cnt      (wcnt),
      .zero     (wcnt_zero)
   );

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Wr_Req || Rd_Req) state_nxt = SETUP;
         SETUP:   state_nxt = WAIT;
         WAIT:    if (wcnt_zero) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: purely state-decoded so Reset drops strobes without a clock edge
   always_comb begin
      Mem_CE = 1'b0;
      Mem_OE = 1'b0;
      Mem_WE = 1'b0;
      Busy   = 1'b0;
      Ready  = 1'b0;
      case (state)
         SETUP: begin
            Mem_CE = 1'b1;
            Mem_OE = (op == OP_RD);
            Busy   = 1'b1;
         end
         WAIT: begin
            Mem_CE = 1'b1;
            Mem_OE = (op == OP_RD);
            Mem_WE = (op == OP_WR);
            Busy   = 1'b1;
         end
         DONE:    Ready = 1'b1;
         default: ;
      endcase
   end

   // Operation latch; write wins a same-cycle collision
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                   op <= OP_RD;
      else if (in_idle && Wr_Req)  op <= OP_WR;
      else if (in_idle && Rd_Req)  op <= OP_RD;
   end

   // MAR: the cast truncates upper BUS bits or zero-extends, as widths dictate
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                  MAR <= '0;
      else if (in_idle && LD_MAR) MAR <= ADDR_W'(BUS);
   end

   // MDR: loads only in IDLE; read data captured on the final WAIT edge
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         MDR <= '0;
      else if (in_idle && LD_MDR)
         MDR <= MIO_EN ? Mem_Rdata : BUS;
      else if (state == WAIT && op == OP_RD && wcnt_zero)
         MDR <= Mem_Rdata;
   end

   assign Mem_Addr  = MAR;
   assign Mem_Wdata = MDR;

`ifdef MEM_PORT_PROTOCOL_CHK_EN
   logic proto_evt;
   assign proto_evt = ((Rd_Req || Wr_Req) && !in_idle) || (Rd_Req && Wr_Req);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Err      <= 1'b0;
         Drop_Cnt <= '0;
      end else if (proto_evt) begin
         Err <= 1'b1;
         if (Drop_Cnt != 4'hF) Drop_Cnt <= Drop_Cnt + 4'd1;
      end
   end
`endif
endmodule
